// File: rtl/stack_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : stack_op_sequencer_if
// Brief    : Command bus (decode side) and stack bus bundled for the sequencer
// Revision : 1.0  initial release
// ============================================================================
interface stack_op_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] imm;
  logic             ready;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             stack_push;
  logic             stack_pop;
  logic             stack_tos;
  logic [WIDTH-1:0] stack_din;
  logic [WIDTH-1:0] stack_dout;
  logic             stack_empty;

  modport master (
    input  start, opcode, imm, stack_dout, stack_empty,
    output ready, done, err, result, zero,
           stack_push, stack_pop, stack_tos, stack_din
  );

  modport slave (
    output start, opcode, imm, stack_dout, stack_empty,
    input  ready, done, err, result, zero,
           stack_push, stack_pop, stack_tos, stack_din
  );
endinterface
`default_nettype wire

// File: rtl/stack_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stack_op_sequencer
// Brief    : Sequences push/pop/tos strobes to an 8-bit LIFO and evaluates ALU ops
// Revision : 1.0  initial release
// ============================================================================
module stack_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  wire logic               clk,
  input  wire logic               rst,
  stack_op_sequencer_if.master    bus
);

  localparam logic [2:0] c_OP_PUSHI = 3'b000;
  localparam logic [2:0] c_OP_POP   = 3'b001;
  localparam logic [2:0] c_OP_ADD   = 3'b010;
  localparam logic [2:0] c_OP_SUB   = 3'b011;
  localparam logic [2:0] c_OP_AND   = 3'b100;
  localparam logic [2:0] c_OP_OR    = 3'b101;
  localparam logic [2:0] c_OP_NOT   = 3'b110;
  localparam logic [2:0] c_OP_DUP   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP1 = 3'd1,
    S_POP2 = 3'd2,
    S_TOS  = 3'd3,
    S_PUSH = 3'd4,
    S_CAPT = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_result;
  logic             r_uflow;
  logic             w_uflow;
  logic             w_push;
  logic             w_pop;
  logic             w_tos;
  logic [WIDTH-1:0] w_alu;

  // In PUSH, stack_dout holds B (second popped operand or refreshed top).
  always_comb begin
    w_alu = bus.stack_dout;
    case (r_op)
      c_OP_PUSHI: w_alu = r_imm;
      c_OP_ADD:   w_alu = bus.stack_dout + r_a;
      c_OP_SUB:   w_alu = bus.stack_dout - r_a;
      c_OP_AND:   w_alu = bus.stack_dout & r_a;
      c_OP_OR:    w_alu = bus.stack_dout | r_a;
      c_OP_NOT:   w_alu = ~bus.stack_dout;
      default:    w_alu = bus.stack_dout;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_tos   = 1'b0;
    w_uflow = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.opcode)
            c_OP_PUSHI: w_next = S_PUSH;
            c_OP_DUP:   w_next = S_TOS;
            default:    w_next = S_POP1;
          endcase
        end
      end
      S_POP1: begin
        if (bus.stack_empty) begin
          w_next  = S_DONE;
          w_uflow = 1'b1;
        end else begin
          w_pop = 1'b1;
          case (r_op)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR: w_next = S_POP2;
            c_OP_NOT:                              w_next = S_PUSH;
            default:                               w_next = S_CAPT;
          endcase
        end
      end
      S_POP2: begin
        if (bus.stack_empty) begin
          w_next  = S_DONE;
          w_uflow = 1'b1;
        end else begin
          w_pop  = 1'b1;
          w_next = S_PUSH;
        end
      end
      S_TOS: begin
        if (bus.stack_empty) begin
          w_next  = S_DONE;
          w_uflow = 1'b1;
        end else begin
          w_tos  = 1'b1;
          w_next = S_PUSH;
        end
      end
      S_PUSH: begin
        w_push = 1'b1;
        w_next = S_DONE;
      end
      S_CAPT:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_op     <= c_OP_PUSHI;
      r_imm    <= '0;
      r_a      <= '0;
      r_result <= '0;
      r_uflow  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.start) begin
        r_op  <= bus.opcode;
        r_imm <= bus.imm;
      end
      if (r_state == S_POP2) begin
        r_a <= bus.stack_dout;
      end
      if (r_state == S_PUSH) begin
        r_result <= w_alu;
      end else if (r_state == S_CAPT) begin
        r_result <= bus.stack_dout;
      end
      // Flag is frozen through DONE so err can be qualified by it there.
      if (r_state != S_DONE) begin
        r_uflow <= w_uflow;
      end
    end
  end

  assign bus.ready      = (r_state == S_IDLE);
  assign bus.done       = (r_state == S_DONE);
  assign bus.err        = (r_state == S_DONE) && r_uflow;
  assign bus.zero       = (r_state == S_DONE) && (r_result == '0);
  assign bus.result     = r_result;
  assign bus.stack_push = w_push;
  assign bus.stack_pop  = w_pop;
  assign bus.stack_tos  = w_tos;
  assign bus.stack_din  = w_push ? w_alu : '0;

endmodule
`default_nettype wire

// File: tb/tb_stack_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_op_sequencer
// Brief    : Directed stimulus with scoreboard; behavioural LIFO as the stack
// Revision : 1.0  initial release
// ============================================================================
module tb_stack_op_sequencer;

  localparam logic [2:0] c_PUSHI = 3'b000;
  localparam logic [2:0] c_POP   = 3'b001;
  localparam logic [2:0] c_ADD   = 3'b010;
  localparam logic [2:0] c_SUB   = 3'b011;
  localparam logic [2:0] c_AND   = 3'b100;
  localparam logic [2:0] c_OR    = 3'b101;
  localparam logic [2:0] c_NOT   = 3'b110;
  localparam logic [2:0] c_DUP   = 3'b111;

  typedef struct {
    string name;
    int    res;
    int    err;
    int    zero;
    int    lat;
    int    np;
    int    npo;
    int    nt;
    int    t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  stack_op_sequencer_if #(.WIDTH(8)) bus();

  stack_op_sequencer #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stack: registered dout, pop on empty ignored, push on full dropped.
  logic [7:0] mem [8];
  int         sp = 0;
  logic       model_clr = 1'b1;

  always @(posedge clk) begin
    if (model_clr) begin
      sp             <= 0;
      bus.stack_dout <= 8'h00;
    end else if (bus.stack_push) begin
      if (sp < 8) begin
        mem[sp] <= bus.stack_din;
        sp      <= sp + 1;
      end
      bus.stack_dout <= bus.stack_din;
    end else if (bus.stack_pop && sp > 0) begin
      bus.stack_dout <= mem[sp-1];
      sp             <= sp - 1;
    end else if (bus.stack_tos && sp > 0) begin
      bus.stack_dout <= mem[sp-1];
    end
  end

  assign bus.stack_empty = (sp == 0);

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Monitor: strobe accounting per command, scoreboard pop on done.
  int n_push = 0, n_pop = 0, n_tos = 0, illegal = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      n_push = 0; n_pop = 0; n_tos = 0; illegal = 0;
    end else begin
      n_push += int'(bus.stack_push);
      n_pop  += int'(bus.stack_pop);
      n_tos  += int'(bus.stack_tos);
      if ((int'(bus.stack_push) + int'(bus.stack_pop) + int'(bus.stack_tos)) > 1 ||
          (bus.stack_pop && bus.stack_empty))
        illegal = 1;
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk({e.name, ".result"},  int'(bus.result), e.res);
          chk({e.name, ".err"},     int'(bus.err),    e.err);
          chk({e.name, ".zero"},    int'(bus.zero),   e.zero);
          chk({e.name, ".latency"}, cyc - e.t0,       e.lat);
          chk({e.name, ".pushes"},  n_push,           e.np);
          chk({e.name, ".pops"},    n_pop,            e.npo);
          chk({e.name, ".tos"},     n_tos,            e.nt);
          chk({e.name, ".strobe_legal"}, illegal,     0);
        end
        n_push = 0; n_pop = 0; n_tos = 0; illegal = 0;
      end
    end
  end

  task automatic wait_ready(input string nm);
    int w = 0;
    while (!bus.ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.ready) chk({nm, ".ready_timeout"}, 0, 1);
  endtask

  task automatic issue(input string nm, input logic [2:0] op, input logic [7:0] im,
                       input int r, input int e, input int z, input int lat,
                       input int np, input int npo, input int nt);
    exp_t x;
    wait_ready(nm);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.imm    = im;
    x = '{name: nm, res: r, err: e, zero: z, lat: lat, np: np, npo: npo, nt: nt, t0: cyc};
    sb.push_back(x);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.opcode = 3'b000;
    bus.imm    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ready",  int'(bus.ready),      1);
    chk("reset.done",   int'(bus.done),       0);
    chk("reset.err",    int'(bus.err),        0);
    chk("reset.zero",   int'(bus.zero),       0);
    chk("reset.result", int'(bus.result),     0);
    chk("reset.push",   int'(bus.stack_push), 0);
    chk("reset.din",    int'(bus.stack_din),  0);
    rst       = 1'b1;
    model_clr = 1'b0;
    @(posedge clk); #1;

    //    name          op       imm    res err z lat push pop tos
    issue("pushi5",     c_PUSHI, 8'd5,    5, 0, 0, 2, 1, 0, 0);
    issue("pushi3",     c_PUSHI, 8'd3,    3, 0, 0, 2, 1, 0, 0);
    issue("sub",        c_SUB,   8'd0,    2, 0, 0, 4, 1, 2, 0);
    issue("pop2",       c_POP,   8'd0,    2, 0, 0, 3, 0, 1, 0);
    issue("pushi200",   c_PUSHI, 8'd200,200, 0, 0, 2, 1, 0, 0);
    issue("pushi100",   c_PUSHI, 8'd100,100, 0, 0, 2, 1, 0, 0);
    issue("add_wrap",   c_ADD,   8'd0,   44, 0, 0, 4, 1, 2, 0);
    issue("pop44",      c_POP,   8'd0,   44, 0, 0, 3, 0, 1, 0);
    issue("add_uflow",  c_ADD,   8'd0,   44, 1, 0, 2, 0, 0, 0);
    issue("pushi7",     c_PUSHI, 8'd7,    7, 0, 0, 2, 1, 0, 0);
    issue("dup",        c_DUP,   8'd0,    7, 0, 0, 3, 1, 0, 1);
    issue("and",        c_AND,   8'd0,    7, 0, 0, 4, 1, 2, 0);
    issue("pop7",       c_POP,   8'd0,    7, 0, 0, 3, 0, 1, 0);
    issue("pop_uflow",  c_POP,   8'd0,    7, 1, 0, 2, 0, 0, 0);
    issue("pushi0",     c_PUSHI, 8'd0,    0, 0, 1, 2, 1, 0, 0);
    issue("not",        c_NOT,   8'd0,  255, 0, 0, 3, 1, 1, 0);
    issue("pushi0b",    c_PUSHI, 8'd0,    0, 0, 1, 2, 1, 0, 0);
    issue("pop0",       c_POP,   8'd0,    0, 0, 1, 3, 0, 1, 0);
    issue("popff",      c_POP,   8'd0,  255, 0, 0, 3, 0, 1, 0);
    issue("pushi3b",    c_PUSHI, 8'd3,    3, 0, 0, 2, 1, 0, 0);
    issue("pushi5b",    c_PUSHI, 8'd5,    5, 0, 0, 2, 1, 0, 0);
    issue("sub_borrow", c_SUB,   8'd0,  254, 0, 0, 4, 1, 2, 0);
    issue("pushi0f",    c_PUSHI, 8'h0F,  15, 0, 0, 2, 1, 0, 0);
    issue("or",         c_OR,    8'd0,  255, 0, 0, 4, 1, 2, 0);
    issue("popor",      c_POP,   8'd0,  255, 0, 0, 3, 0, 1, 0);
    issue("pushi9",     c_PUSHI, 8'd9,    9, 0, 0, 2, 1, 0, 0);
    issue("add_uflow2", c_ADD,   8'd0,    9, 1, 0, 3, 0, 1, 0);
    issue("dup_uflow",  c_DUP,   8'd0,    9, 1, 0, 2, 0, 0, 0);

    // A start raised while the sequencer is busy must be dropped.
    issue("pushi11",    c_PUSHI, 8'h11,  17, 0, 0, 2, 1, 0, 0);
    bus.start  = 1'b1;
    bus.opcode = c_POP;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    issue("pop11",      c_POP,   8'd0,   17, 0, 0, 3, 0, 1, 0);

    // Asynchronous reset in the middle of an ADD (second pop cycle).
    issue("pushi1",     c_PUSHI, 8'd1,    1, 0, 0, 2, 1, 0, 0);
    issue("pushi2",     c_PUSHI, 8'd2,    2, 0, 0, 2, 1, 0, 0);
    wait_ready("add_rst");
    bus.start  = 1'b1;
    bus.opcode = c_ADD;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst.pop",   int'(bus.stack_pop), 1);
    chk("pre_rst.ready", int'(bus.ready),     0);
    rst = 1'b0;
    #1;
    chk("mid_rst.ready",  int'(bus.ready),      1);
    chk("mid_rst.done",   int'(bus.done),       0);
    chk("mid_rst.err",    int'(bus.err),        0);
    chk("mid_rst.zero",   int'(bus.zero),       0);
    chk("mid_rst.result", int'(bus.result),     0);
    chk("mid_rst.pop",    int'(bus.stack_pop),  0);
    chk("mid_rst.push",   int'(bus.stack_push), 0);
    chk("mid_rst.tos",    int'(bus.stack_tos),  0);
    chk("mid_rst.din",    int'(bus.stack_din),  0);
    model_clr = 1'b1;
    @(posedge clk); #1;
    model_clr = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    issue("pushi5a",    c_PUSHI, 8'h5A,  90, 0, 0, 2, 1, 0, 0);

    begin
      int w = 0;
      while (sb.size() != 0 && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
    end
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
